alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Registered valid/ready wrapper around the combinational alu. Accepts one op
//  {a, b, control} per cycle, holds operands in a stage-1 register that drives
//  the alu, and captures {result, overflow, zero, equal, control} into a
//  DEPTH-entry result FIFO drained by the consumer (writeback/sequencer).
// PARAMETERS
//  N      32  operand/result width; only 32 supported, passed through to alu.
//  DEPTH  2   result FIFO entries; power of two, 2..16.
// PORTS
//  clk           in   1       clock; all state updates on rising edge.
//  rst           in   1       reset, asynchronous, active-high.
//  in_valid      in   1       producer offers an op.
//  in_ready      out  1       stage can accept; transfer = in_valid & in_ready.
//  in_a, in_b    in   N       operands.
//  in_control    in   4       alu_control_t opcode.
//  out_valid     out  1       FIFO head holds a result.
//  out_ready     in   1       consumer takes head; pop = out_valid & out_ready.
//  out_result    out  N       head result.
//  out_overflow  out  1       head overflow flag.
//  out_zero      out  1       head zero flag.
//  out_equal     out  1       head equal flag.
//  out_control   out  4       opcode that produced the head entry.
//  fifo_count    out  log2(DEPTH)+1  occupied FIFO entries.
//  stat_ops      out  16      ops retired (ALU_STATS_EN only, else 0).
//  stat_ovf      out  16      retired ops with overflow=1 (ALU_STATS_EN, else 0).
// BEHAVIOUR
//  - Reset (async, while rst=1): s1_valid=0, FIFO rd/wr pointers=0, count=0,
//    out_valid=0, fifo_count=0, stat_*=0; out_* data = 0. In-flight ops dropped.
//  - Stage 1: on transfer, {a,b,control} -> s1 regs, s1_valid=1. The alu sees
//    only s1 regs; in_* never reach the alu combinationally.
//  - advance = s1_valid & ((count < DEPTH) | pop). On advance, the alu outputs
//    are written at wr_ptr and s1_valid clears unless a new transfer occurs
//    in the same cycle (then s1 reloads, s1_valid stays 1).
//  - in_ready = !s1_valid | advance (combinational; includes pop path).
//  - Latency: op accepted at edge E0 -> out_valid=1 after E1 when FIFO empty.
//    Throughput 1 op/cycle while out_ready=1.
//  - FIFO: count += advance - pop; pointers wrap mod DEPTH. Full
//    (count=DEPTH) with no pop -> advance=0, s1 holds, in_ready=0.
//    Push+pop at full allowed, count unchanged. Pop at empty impossible.
//  - out_* are registered FIFO head; stable while out_valid & !out_ready.
//  - Arithmetic/flags are the alu's exactly; no re-computation here.
//  - Order preserved: results leave in acceptance order.
// CONFIGURATION
//  ALU_STATS_EN defined: stat_ops += 1 per advance, stat_ovf += 1 per advance
//   with alu overflow=1; both saturate at 16'hFFFF; cleared only by rst.
//  ALU_STATS_EN undefined: counters not built, stat_ops = stat_ovf = 0.
// TESTING
//  1 rst=1 mid-stream with s1_valid=1, count=2 -> next cycle out_valid=0,
//    fifo_count=0, in_ready=1; no stale result ever appears afterwards.
//  2 out_ready=1, push ALU_ADD 7FFFFFFF+00000001 at E0 -> after E1 out_result
//    80000000, out_overflow=1, out_zero=0, out_equal=0, out_control=ALU_ADD.
//  3 out_ready=0, push 4 ops (DEPTH=2) -> 2 in FIFO, 1 in s1, in_ready=0 on
//    4th; raise out_ready -> all 4 drain in order, 1/cycle, none lost.
//  4 FIFO full, s1 full, out_ready=1 and in_valid=1 same cycle -> pop, push,
//    and new accept together; fifo_count stays 2.
//  5 ALU_SUB 12345678-12345678 -> result 0, zero=1, equal=1, overflow=0.
//  6 ALU_STATS_EN: 3 ops, one overflowing -> stat_ops=3, stat_ovf=1; 70000
//    ops -> stat_ops=FFFF. Without macro both read 0.
//  Scoreboard vs alu_behavioural on every pop, plus 1000 random ops with
//  random in_valid/out_ready stalls.

Source files
------------

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage.sv
//
// Purpose
//   Registered valid/ready issue stage around a combinational 32-bit ALU.
//   One op {a, b, control} is accepted per cycle into a stage-1 operand
//   register. The register drives the ALU, and the ALU outputs
//   {result, overflow, zero, equal, control} are captured into a DEPTH-entry
//   result FIFO. The consumer drains the FIFO. The FIFO head is presented on
//   registered outputs.
//
// Optional feature
//   ALU_STATS_EN : when defined, the stage builds two 16-bit saturating
//                  counters. stat_ops counts retired ops and stat_ovf counts
//                  retired ops that overflowed. When undefined, both outputs
//                  are tied to zero.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   producer handshake (transfer = in_valid & in_ready)
//   in_a, in_b          operands (N bits)
//   in_control          alu_control_t opcode (4 bits)
//   out_valid/out_ready consumer handshake (pop = out_valid & out_ready)
//   out_result          head result (N bits)
//   out_overflow/zero/equal  head flags
//   out_control         opcode that produced the head entry
//   fifo_count          occupied FIFO entries
//   stat_ops, stat_ovf  retired-op statistics (16 bits each)
//
// Opcode encoding (alu_control_t)
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU,
//   8 SLL, 9 SRL, A SRA (shift amount = b[4:0]); other codes give result 0.
// -----------------------------------------------------------------------------

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA
  } alu_control_t;
endpackage

// Combinational ALU.
// overflow is the signed two's-complement overflow of ADD/SUB and is 0 for
// every other op. zero reflects the result. equal compares the operands.
module alu #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal
);
  import alu_pkg::*;

  localparam int SH_W = $clog2(N);

  logic [N-1:0]    sum_s;
  logic [N-1:0]    diff_s;
  logic [SH_W-1:0] shamt_s;

  assign sum_s   = a + b;
  assign diff_s  = a - b;
  assign shamt_s = b[SH_W-1:0];

  // Opcode decode, flag generation
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        result   = sum_s;
        overflow = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = diff_s;
        overflow = (a[N-1] != b[N-1]) && (diff_s[N-1] != a[N-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(N-1){1'b0}}, (a < b)};
      ALU_SLL:  result = a << shamt_s;
      ALU_SRL:  result = a >> shamt_s;
      ALU_SRA:  result = $signed(a) >>> shamt_s;
      default:  result = '0;
    endcase
    zero  = (result == '0);
    equal = (a == b);
  end
endmodule

module alu_issue_stage #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  input  logic [3:0]                 in_control,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_result,
  output logic                       out_overflow,
  output logic                       out_zero,
  output logic                       out_equal,
  output logic [3:0]                 out_control,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                stat_ops,
  output logic [15:0]                stat_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Entry layout: {control[3:0], equal, zero, overflow, result[N-1:0]}
  localparam int ENT_W = N + 7;

  // Stage-1 operand register
  logic [N-1:0]     s1_a_r;
  logic [N-1:0]     s1_b_r;
  logic [3:0]       s1_ctrl_r;
  logic             s1_valid_r;

  // ALU outputs
  logic [N-1:0]     alu_result_s;
  logic             alu_overflow_s;
  logic             alu_zero_s;
  logic             alu_equal_s;
  logic [ENT_W-1:0] entry_s;

  // Result FIFO
  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [ENT_W-1:0] head_r;
  logic             out_valid_r;

  // Handshake / next-state terms
  logic             pop_s;
  logic             not_full_s;
  logic             advance_s;
  logic             xfer_s;
  logic [CNT_W-1:0] count_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [ENT_W-1:0] head_next_s;

  alu #(.N(N)) u_alu (
    .a        (s1_a_r),
    .b        (s1_b_r),
    .control  (s1_ctrl_r),
    .result   (alu_result_s),
    .overflow (alu_overflow_s),
    .zero     (alu_zero_s),
    .equal    (alu_equal_s)
  );

  assign entry_s = {s1_ctrl_r, alu_equal_s, alu_zero_s, alu_overflow_s, alu_result_s};

  // out_valid_r always mirrors count_r != 0, so a pop never targets an empty FIFO.
  assign pop_s      = out_valid_r & out_ready;
  assign not_full_s = (count_r < CNT_W'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO can still accept the stage-1 op.
  assign advance_s  = s1_valid_r & (not_full_s | pop_s);
  assign in_ready   = ~s1_valid_r | advance_s;
  assign xfer_s     = in_valid & in_ready;

  // Next FIFO occupancy, read pointer and head entry
  always_comb begin
    count_next_s  = count_r;
    rd_ptr_next_s = rd_ptr_r;
    head_next_s   = head_r;
    case ({advance_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    // A write that lands on the next head slot can only happen when the FIFO
    // is empty after the pop. In that case the ALU output bypasses the memory.
    if (advance_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = entry_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Stage-1 operand register and its valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_ctrl_r  <= 4'h0;
    end else if (xfer_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= in_a;
      s1_b_r     <= in_b;
      s1_ctrl_r  <= in_control;
    end else if (advance_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // FIFO storage; contents are only observed through head_r, so no reset is needed
  always_ff @(posedge clk) begin
    if (advance_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (advance_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
    end
  end

  // Registered FIFO head; it holds while the FIFO stays non-empty without a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      head_r      <= '0;
    end else begin
      out_valid_r <= (count_next_s != '0);
      if (count_next_s != '0) begin
        head_r <= head_next_s;
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign out_result   = head_r[N-1:0];
  assign out_overflow = head_r[N];
  assign out_zero     = head_r[N+1];
  assign out_equal    = head_r[N+2];
  assign out_control  = head_r[N+6:N+3];
  assign fifo_count   = count_r;

`ifdef ALU_STATS_EN
  logic [15:0] stat_ops_r;
  logic [15:0] stat_ovf_r;

  // Saturating retired-op statistics; cleared only by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_r <= 16'h0000;
      stat_ovf_r <= 16'h0000;
    end else if (advance_s) begin
      if (stat_ops_r != 16'hFFFF) begin
        stat_ops_r <= stat_ops_r + 16'h0001;
      end
      if (alu_overflow_s && (stat_ovf_r != 16'hFFFF)) begin
        stat_ovf_r <= stat_ovf_r + 16'h0001;
      end
    end
  end

  assign stat_ops = stat_ops_r;
  assign stat_ovf = stat_ovf_r;
`else
  assign stat_ops = 16'h0000;
  assign stat_ovf = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage (N=32, DEPTH=2).
module tb_alu_issue_stage;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'h0;
  logic [31:0] in_b = 32'h0;
  logic [3:0]  in_control = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_zero;
  logic        out_equal;
  logic [3:0]  out_control;
  logic [1:0]  fifo_count;
  logic [15:0] stat_ops;
  logic [15:0] stat_ovf;

  int checks = 0;
  int errors = 0;

  logic [38:0] sb_q[$];
  logic [38:0] sb_head;
  logic [38:0] dut_ent;

  alu_issue_stage #(.N(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_control(in_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_zero(out_zero), .out_equal(out_equal), .out_control(out_control),
    .fifo_count(fifo_count), .stat_ops(stat_ops), .stat_ovf(stat_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: 64-bit signed arithmetic, returns {ctrl,eq,zero,ovf,result}
  function automatic logic [38:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    longint sa, sb, wide;
    logic [31:0] r;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    r  = 32'h0;
    case (c)
      OP_ADD:  begin wide = sa + sb; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      OP_SUB:  begin wide = sa - sb; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  begin wide = sa >>> b[4:0]; r = wide[31:0]; end
      default: r = 32'h0;
    endcase
    return {c, (a == b), (r == 32'h0), ov, r};
  endfunction

  // Scoreboard: push on accept, compare on pop (sampled on the falling edge)
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        dut_ent = {out_control, out_equal, out_zero, out_overflow, out_result};
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected actual=%h required=no_output", dut_ent);
        end else begin
          sb_head = sb_q.pop_front();
          if (dut_ent !== sb_head) begin
            errors++;
            $display("FAIL sb_pop actual=%h required=%h", dut_ent, sb_head);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_a, in_b, in_control));
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        eq;
  } vec_t;

  vec_t vecs[15];

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    in_a = a; in_b = b; in_control = c; in_valid = 1'b1;
  endtask

  // Three ADD ops back-to-back with out_ready=0: leaves 2 in FIFO, 1 in s1
  task automatic fill3();
    for (int i = 0; i < 3; i++) begin
      drive(32'(i), 32'd100, OP_ADD);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int accepted;
    int cyc;
    logic xfer;
    logic [31:0] ra;

    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, OP_ADD,  32'h80000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h12345678, 32'h12345678, OP_SUB,  32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, OP_ADD,  32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'h80000000, 32'h00000001, OP_SUB,  32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'hF0F0F0F0, 32'h0FF00FF0, OP_AND,  32'h00F000F0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000000, 32'h00000000, OP_OR,   32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{32'hA5A5A5A5, 32'hFFFFFFFF, OP_XOR,  32'h5A5A5A5A, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h00000000, 32'h00000000, OP_NOR,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'hFFFFFFFF, 32'h00000001, OP_SLT,  32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, OP_SLTU, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h00000001, 32'h0000001F, OP_SLL,  32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h80000000, 32'h00000004, OP_SRL,  32'h08000000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h80000000, 32'h00000004, OP_SRA,  32'hF8000000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h00000001, 32'h00000002, 4'hF,    32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{32'h40000000, 32'h40000000, OP_ADD,  32'h80000000, 1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_control", 64'(out_control), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Table-driven single ops: accept at E0, result visible after E1
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("tbl_valid", 64'(out_valid), 64'd1);
      chk("tbl_result", 64'(out_result), 64'(vecs[i].res));
      chk("tbl_ovf", 64'(out_overflow), 64'(vecs[i].ovf));
      chk("tbl_zero", 64'(out_zero), 64'(vecs[i].zero));
      chk("tbl_equal", 64'(out_equal), 64'(vecs[i].eq));
      chk("tbl_control", 64'(out_control), 64'(vecs[i].c));
    end
    @(posedge clk); #1;
    chk("tbl_empty", 64'(out_valid), 64'd0);

    // Backpressure: 4 ops with out_ready=0, then simultaneous pop/push/accept
    out_ready = 1'b0;
    fill3();
    drive(32'd3, 32'd100, OP_ADD);
    @(negedge clk);
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    chk("bp_count_full", 64'(fifo_count), 64'd2);
    chk("bp_head_hold", 64'(out_result), 64'd100);
    @(posedge clk); #1;
    chk("bp_head_stable", 64'(out_result), 64'd100);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_pop", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_count_pushpop", 64'(fifo_count), 64'd2);
    chk("bp_head1", 64'(out_result), 64'd101);
    @(posedge clk); #1;
    chk("bp_head2", 64'(out_result), 64'd102);
    chk("bp_count2", 64'(fifo_count), 64'd2);
    @(posedge clk); #1;
    chk("bp_head3", 64'(out_result), 64'd103);
    chk("bp_count3", 64'(fifo_count), 64'd1);
    @(posedge clk); #1;
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_count0", 64'(fifo_count), 64'd0);

    // Reset mid-stream with s1 full and FIFO full
    out_ready = 1'b0;
    fill3();
    in_valid = 1'b0;
    chk("mid_pre_count", 64'(fifo_count), 64'd2);
    rst = 1'b1;
    #2;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_fifo_count", 64'(fifo_count), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", 64'(out_valid), 64'd0);
    end

    // Random traffic with stalls on both sides
    accepted = 0;
    cyc = 0;
    in_valid = 1'b0;
    while (accepted < 1000 && cyc < 20000) begin
      @(negedge clk);
      xfer = in_valid && in_ready;
      if (xfer) accepted++;
      @(posedge clk); #1;
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || xfer) begin
        if (accepted < 1000 && $urandom_range(0, 3) != 0) begin
          ra = rnd32();
          drive(ra, ($urandom_range(0, 4) == 0) ? ra : rnd32(), 4'($urandom_range(0, 15)));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_accepted", 64'(accepted), 64'd1000);
    cyc = 0;
    while ((sb_q.size() != 0 || out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_drain_q", 64'(sb_q.size()), 64'd0);
    chk("rand_drain_valid", 64'(out_valid), 64'd0);

`ifdef ALU_STATS_EN
    rst = 1'b1;
    #2;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("stat_rst", 64'(stat_ops), 64'd0);
    drive(32'h7FFFFFFF, 32'h1, OP_ADD);
    @(posedge clk); #1;
    drive(32'h1, 32'h1, OP_ADD);
    @(posedge clk); #1;
    drive(32'h5, 32'h3, OP_SUB);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stat_ops3", 64'(stat_ops), 64'd3);
    chk("stat_ovf1", 64'(stat_ovf), 64'd1);
    drive(32'h1, 32'h1, OP_ADD);
    repeat (70000) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stat_ops_sat", 64'(stat_ops), 64'hFFFF);
    chk("stat_ovf_keep", 64'(stat_ovf), 64'd1);
`else
    chk("stat_ops_off", 64'(stat_ops), 64'd0);
    chk("stat_ovf_off", 64'(stat_ovf), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
